// File: rtl/countdown_timer.sv
// MM:SS BCD cooking timer; counts down once per TICKS_PER_SEC cycles while mag_on is high.
// Latency: registered outputs, first decrement TICKS_PER_SEC edges after counting starts.
// No backpressure. Optional +30 s button is built only when TIMER_ADD30_EN is defined.
module countdown_timer #(
    parameter int TICKS_PER_SEC = 100
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        clearn,
    input  logic        load,
    input  logic [15:0] load_time,
    input  logic        mag_on,
    input  logic        add30,
    output logic [3:0]  min_tens,
    output logic [3:0]  min_ones,
    output logic [3:0]  sec_tens,
    output logic [3:0]  sec_ones,
    output logic        timer_done
);

    localparam int PW = $clog2(TICKS_PER_SEC);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_SEC - 1);

    typedef struct packed {
        logic [3:0] mt;
        logic [3:0] mo;
        logic [3:0] st;
        logic [3:0] so;
    } bcd_time_t;

    typedef enum logic [1:0] {
        IDLE,
        PAUSED,
        RUNNING
    } state_t;

    bcd_time_t      time_q, time_d;
    logic [PW-1:0]  presc_q, presc_d;
    logic           done_q, done_d;
    state_t         state;

    function automatic logic [3:0] clamp_digit(input logic [3:0] d, input logic [3:0] max);
        return (d > max) ? max : d;
    endfunction

    function automatic bcd_time_t clamp_time(input logic [15:0] raw);
        bcd_time_t r;
        r.mt = clamp_digit(raw[15:12], 4'd9);
        r.mo = clamp_digit(raw[11:8],  4'd9);
        r.st = clamp_digit(raw[7:4],   4'd5);
        r.so = clamp_digit(raw[3:0],   4'd9);
        return r;
    endfunction

    // Only called with a nonzero time, so the minute tens never underflow.
    function automatic bcd_time_t dec_time(input bcd_time_t t);
        bcd_time_t r;
        r = t;
        if (t.so != 4'd0) begin
            r.so = t.so - 4'd1;
        end else begin
            r.so = 4'd9;
            if (t.st != 4'd0) begin
                r.st = t.st - 4'd1;
            end else begin
                r.st = 4'd5;
                if (t.mo != 4'd0) begin
                    r.mo = t.mo - 4'd1;
                end else begin
                    r.mo = 4'd9;
                    r.mt = t.mt - 4'd1;
                end
            end
        end
        return r;
    endfunction

`ifdef TIMER_ADD30_EN
    // Anything at or above 99:30 would overflow the display, so pin it to 99:59.
    function automatic bcd_time_t add30_time(input bcd_time_t t);
        bcd_time_t r;
        r = t;
        if (t.mt == 4'd9 && t.mo == 4'd9 && t.st >= 4'd3) begin
            r = '{mt: 4'd9, mo: 4'd9, st: 4'd5, so: 4'd9};
        end else if (t.st >= 4'd3) begin
            r.st = t.st - 4'd3;
            if (t.mo == 4'd9) begin
                r.mo = 4'd0;
                r.mt = t.mt + 4'd1;
            end else begin
                r.mo = t.mo + 4'd1;
            end
        end else begin
            r.st = t.st + 4'd3;
        end
        return r;
    endfunction
`else
    logic unused_add30;
    assign unused_add30 = add30;
`endif

    always_comb begin
        state = RUNNING;
        if (time_q == '0) begin
            state = IDLE;
        end else if (!mag_on) begin
            state = PAUSED;
        end
    end

    always_comb begin
        time_d  = time_q;
        presc_d = presc_q;
        if (!clearn) begin
            time_d  = '0;
            presc_d = '0;
        end else if (load) begin
            time_d  = clamp_time(load_time);
            presc_d = '0;
`ifdef TIMER_ADD30_EN
        end else if (add30) begin
            time_d  = add30_time(time_q);
`endif
        end else begin
            case (state)
                IDLE:    presc_d = '0;
                PAUSED:  presc_d = presc_q;
                RUNNING: begin
                    if (presc_q == PRESC_LAST) begin
                        presc_d = '0;
                        time_d  = dec_time(time_q);
                    end else begin
                        presc_d = presc_q + PW'(1);
                    end
                end
                default: presc_d = '0;
            endcase
        end
        done_d = (time_d == '0);
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            time_q  <= '0;
            presc_q <= '0;
            done_q  <= 1'b1;
        end else begin
            time_q  <= time_d;
            presc_q <= presc_d;
            done_q  <= done_d;
        end
    end

    assign min_tens   = time_q.mt;
    assign min_ones   = time_q.mo;
    assign sec_tens   = time_q.st;
    assign sec_ones   = time_q.so;
    assign timer_done = done_q;

endmodule
